generic_ram_loader: RTL and testbench
=====================================

Name: generic_ram_loader

Overview:
- Writer-side counterpart to the generic block ROM. It accepts a stream of words on a valid/ready handshake and writes them sequentially into an internal block RAM.
- After loading, the RAM is read through a ROM-style port with a registered output and 1-cycle latency.
- Used to program FSM transition/output tables at run time instead of fixing them at synthesis.

Parameters:
- gAddressWidth, 4, table address width; RAM depth = 2**gAddressWidth.
- gDataWidth, 8, word width.
- gLoadWords, 2**gAddressWidth, words per load sequence. Legal range is 1..2**gAddressWidth; elaboration fails outside this range.

Ports:
- iClock  in  1  clock; all logic on the rising edge.
- iResetN  in  1  asynchronous, active-low reset.
- iStart  in  1  single-cycle request to begin a load sequence.
- iAbort  in  1  terminates a load in progress.
- iWrData  in  gDataWidth  load word.
- iWrValid  in  1  iWrData is valid.
- oWrReady  out  1  loader accepts a word this cycle.
- oBusy  out  1  a load sequence is in progress.
- oDone  out  1  the last load completed all gLoadWords words.
- oLoadCount  out  gAddressWidth+1  number of words accepted in the current or last load.
- iRdAddress  in  gAddressWidth  read address.
- oRdData  out  gDataWidth  registered read data.

Behaviour:
- Reset (iResetN=0, asynchronous):
  - state=IDLE.
  - oWrReady=0, oBusy=0, oDone=0, oLoadCount=0, oRdData=0.
  - RAM contents are not reset.
- States: IDLE, LOAD, DONE.
- IDLE or DONE, iStart=1 and iAbort=0:
  - next state LOAD.
  - write address and oLoadCount cleared to 0.
  - oDone cleared.
- LOAD:
  - oWrReady=1 and oBusy=1 (both combinational from state).
  - A beat occurs when iWrValid=1 and oWrReady=1: RAM[address] <= iWrData, address increments, oLoadCount increments.
  - When the beat that makes oLoadCount equal gLoadWords completes, next state is DONE and oDone=1 from the following cycle.
  - The write address does not wrap within one load.
- LOAD, iAbort=1:
  - next state IDLE; no write in that cycle even if iWrValid=1.
  - oDone stays 0; oLoadCount holds its value.
  - Words already written remain in the RAM.
- iStart during LOAD is ignored. iAbort in IDLE or DONE is ignored.
- iStart and iAbort asserted together: abort wins, no state change out of IDLE/DONE.
- DONE: oDone=1, oWrReady=0. Stays in DONE until the next iStart.
- Words presented while oWrReady=0 are not consumed. The upstream holds iWrData stable until the beat.
- Read port:
  - oRdData <= RAM[iRdAddress] on every clock, in every state. Latency is 1 cycle.
  - A read and a write to the same address in the same cycle return the old data (read-first).
- Reset asserted mid-load: returns to IDLE. A partially written table is retained but oDone=0.
- gLoadWords=1: one beat goes IDLE→LOAD→DONE.

Decomposition:
- Shared package holds:
  - state encoding constants (cStateIdle=2'd0, cStateLoad=2'd1, cStateDone=2'd2).
  - the common table address and data width constants used by the FSM-table blocks.
- One sub-module: sdp_block_ram. It is a simple dual-port RAM with one write port, one read-first registered read port, and the block-RAM inference attribute. The loader instantiates it and contains only the control FSM and counters.

Test Plan:
- Reset, then iStart, then 16 beats of data 8'h10..8'h1F (defaults) → oDone rises the cycle after the 16th beat, oLoadCount=16. Reading address 5 gives oRdData=8'h15 one cycle later.
- Toggle iWrValid with gaps (valid every other cycle) → exactly 16 writes, and oWrReady stays 1 throughout LOAD.
- iAbort after 3 beats, coinciding with iWrValid=1 → IDLE, oLoadCount=3, oDone=0. Address 3 keeps its old value.
- Read address 2 in the same cycle as a write of 8'hAA to address 2 → oRdData shows the old value, then 8'hAA on the next read.
- Assert iResetN=0 mid-load at beat 7 → all outputs 0 immediately. Addresses 0..6 are retained on readback.
- iStart and iAbort together in DONE → stays DONE with oDone=1. A subsequent iStart alone restarts the load and clears oDone.

Source files
------------

// File: rtl/generic_ram_loader_pkg.sv
// Shared constants for the run-time programmable FSM-table blocks:
// the default table geometry and the loader state encoding.
package generic_ram_loader_pkg;

    localparam int cTableAddressWidth = 4;
    localparam int cTableDataWidth    = 8;

    localparam logic [1:0] cStateIdle = 2'd0;
    localparam logic [1:0] cStateLoad = 2'd1;
    localparam logic [1:0] cStateDone = 2'd2;

endpackage

// File: rtl/generic_ram_loader_if.sv
// Load stream and table read port of generic_ram_loader. The loader
// itself takes the slave side; whoever feeds and reads the table takes master.
interface generic_ram_loader_if
    import generic_ram_loader_pkg::*;
#(
    parameter int gAddressWidth = cTableAddressWidth,
    parameter int gDataWidth    = cTableDataWidth
) ();

    logic                   iStart;
    logic                   iAbort;
    logic [gDataWidth-1:0]  iWrData;
    logic                   iWrValid;
    logic                   oWrReady;
    logic                   oBusy;
    logic                   oDone;
    logic [gAddressWidth:0] oLoadCount;
    logic [gAddressWidth-1:0] iRdAddress;
    logic [gDataWidth-1:0]  oRdData;

    modport slave (
        input  iStart, iAbort, iWrData, iWrValid, iRdAddress,
        output oWrReady, oBusy, oDone, oLoadCount, oRdData
    );

    modport master (
        output iStart, iAbort, iWrData, iWrValid, iRdAddress,
        input  oWrReady, oBusy, oDone, oLoadCount, oRdData
    );

endinterface

// File: rtl/generic_ram_loader_sdp_block_ram.sv
// Simple dual-port block RAM: one write port, one registered read-first
// read port with a 1-cycle latency.
module sdp_block_ram #(
    parameter int gAddressWidth = 4,
    parameter int gDataWidth    = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en_i,
    input  logic [gAddressWidth-1:0] wr_addr_i,
    input  logic [gDataWidth-1:0]    wr_data_i,
    input  logic [gAddressWidth-1:0] rd_addr_i,
    output logic [gDataWidth-1:0]    rd_data_o
);

    (* ram_style = "block" *)
    logic [gDataWidth-1:0] mem_q [2**gAddressWidth];
    logic [gDataWidth-1:0] rd_data_q;

    // NOTE: the array has no reset branch; resetting it would stop the tools
    // from mapping it onto a block RAM, and the table must survive reset anyway.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Non-blocking read of mem_q sees the pre-write contents: read-first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/generic_ram_loader.sv
// Streams gLoadWords words from a valid/ready source into a block RAM that is
// then read as a ROM. Holds only the control FSM and the load counter.
module generic_ram_loader
    import generic_ram_loader_pkg::*;
#(
    parameter int gAddressWidth = cTableAddressWidth,
    parameter int gDataWidth    = cTableDataWidth,
    parameter int gLoadWords    = 2**gAddressWidth
) (
    input  logic                 iClock,
    input  logic                 iResetN,
    generic_ram_loader_if.slave  bus
);

    if (gLoadWords < 1 || gLoadWords > 2**gAddressWidth) begin : g_bad_load_words
        $error("generic_ram_loader: gLoadWords must lie in 1..2**gAddressWidth");
    end

    localparam logic [gAddressWidth:0] cLoadWords = (gAddressWidth + 1)'(gLoadWords);
    localparam logic [gAddressWidth:0] cCountOne  = (gAddressWidth + 1)'(1);

    logic [1:0]             state_q, state_d;
    logic [gAddressWidth:0] count_q, count_d;
    logic                   wr_en;

    // NOTE: every signal gets its default before the case so that no path
    // leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        wr_en   = 1'b0;
        case (state_q)
            cStateIdle, cStateDone: begin
                if (bus.iStart && !bus.iAbort) begin
                    state_d = cStateLoad;
                    count_d = '0;
                end
            end
            cStateLoad: begin
                if (bus.iAbort) begin
                    state_d = cStateIdle;
                end else if (bus.iWrValid) begin
                    wr_en   = 1'b1;
                    count_d = count_q + cCountOne;
                    if (count_d == cLoadWords) begin
                        state_d = cStateDone;
                    end
                end
            end
            default: state_d = cStateIdle;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of block evaluation order.
    always_ff @(posedge iClock or negedge iResetN) begin
        if (!iResetN) begin
            state_q <= cStateIdle;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // The write address tracks the count; the load ends before it could wrap.
    sdp_block_ram #(
        .gAddressWidth (gAddressWidth),
        .gDataWidth    (gDataWidth)
    ) u_ram (
        .clk       (iClock),
        .rst_n     (iResetN),
        .wr_en_i   (wr_en),
        .wr_addr_i (count_q[gAddressWidth-1:0]),
        .wr_data_i (bus.iWrData),
        .rd_addr_i (bus.iRdAddress),
        .rd_data_o (bus.oRdData)
    );

    assign bus.oWrReady   = (state_q == cStateLoad);
    assign bus.oBusy      = (state_q == cStateLoad);
    assign bus.oDone      = (state_q == cStateDone);
    assign bus.oLoadCount = count_q;

endmodule

// File: tb/tb_generic_ram_loader.sv
// Bench for generic_ram_loader: directed scenarios plus a random phase, with
// read data checked by a scoreboard against a behavioural table model.
module tb_generic_ram_loader;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int LW = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    generic_ram_loader_if #(.gAddressWidth(AW), .gDataWidth(DW)) bus ();

    generic_ram_loader #(
        .gAddressWidth (AW),
        .gDataWidth    (DW),
        .gLoadWords    (LW)
    ) dut (
        .iClock  (clk),
        .iResetN (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Behavioural model: a table, a "loading" flag, a "done" flag and a count.
    bit          m_loading;
    bit          m_done;
    int          m_count;
    logic [DW-1:0] m_mem [2**AW];
    logic [DW-1:0] exp_q [$];

    bit rd_req;
    bit rd_tag_q;
    int checks;
    int errors;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Read-data monitor: a read requested before edge N is visible after edge N.
    always @(posedge clk) rd_tag_q <= rd_req;

    always @(negedge clk) begin
        if (rd_tag_q) begin
            if (exp_q.size() == 0) begin
                check("rd_data_unexpected", 32'(bus.oRdData), 32'hDEAD);
            end else begin
                check("rd_data", 32'(bus.oRdData), 32'(exp_q.pop_front()));
            end
        end
    end

    // One clock of stimulus; called at posedge+1 and returns at posedge+1.
    task automatic step(input bit start, input bit abort, input bit valid,
                        input logic [DW-1:0] data, input logic [AW-1:0] rd_addr,
                        input bit rd_chk);
        bus.iStart     = start;
        bus.iAbort     = abort;
        bus.iWrValid   = valid;
        bus.iWrData    = data;
        bus.iRdAddress = rd_addr;
        rd_req         = rd_chk;
        if (rd_chk) exp_q.push_back(m_mem[rd_addr]);
        check("wr_ready", 32'(bus.oWrReady), 32'(m_loading));
        check("busy", 32'(bus.oBusy), 32'(m_loading));
        if (m_loading) begin
            if (abort) begin
                m_loading = 1'b0;
            end else if (valid) begin
                m_mem[m_count] = data;
                m_count++;
                if (m_count == LW) begin
                    m_loading = 1'b0;
                    m_done    = 1'b1;
                end
            end
        end else if (start && !abort) begin
            m_loading = 1'b1;
            m_done    = 1'b0;
            m_count   = 0;
        end
        @(posedge clk);
        #1;
        check("done", 32'(bus.oDone), 32'(m_done));
        check("load_count", 32'(bus.oLoadCount), 32'(m_count));
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wr_ready"}, 32'(bus.oWrReady), 0);
        check({tag, "_busy"}, 32'(bus.oBusy), 0);
        check({tag, "_done"}, 32'(bus.oDone), 0);
        check({tag, "_load_count"}, 32'(bus.oLoadCount), 0);
        check({tag, "_rd_data"}, 32'(bus.oRdData), 0);
    endtask

    task automatic full_load(input logic [DW-1:0] base);
        step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
        for (int i = 0; i < LW; i++) begin
            step(1'b0, 1'b0, 1'b1, base + DW'(i), '0, 1'b0);
        end
    endtask

    initial begin
        bus.iStart     = 1'b0;
        bus.iAbort     = 1'b0;
        bus.iWrValid   = 1'b0;
        bus.iWrData    = '0;
        bus.iRdAddress = '0;
        rd_req         = 1'b0;
        for (int i = 0; i < 2**AW; i++) m_mem[i] = 'x;

        // Reset state
        #2;
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Full load of 0x10..0x1F, then read address 5
        full_load(8'h10);
        check("full_count", 32'(bus.oLoadCount), 16);
        check("full_done", 32'(bus.oDone), 1);
        step(1'b0, 1'b0, 1'b0, '0, 4'd5, 1'b1);
        idle();

        // Gapped valid: every other cycle, with reads of random addresses
        step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
        for (int i = 0; i < 2 * LW; i++) begin
            step(1'b0, 1'b0, (i % 2) == 1, DW'($urandom), AW'($urandom), 1'b1);
        end
        check("gapped_done", 32'(bus.oDone), 1);

        // Abort after 3 beats, coinciding with valid: address 3 keeps old data
        step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 8'h30 + DW'(i), '0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 8'h77, 4'd3, 1'b1);
        check("abort_count", 32'(bus.oLoadCount), 3);
        check("abort_done", 32'(bus.oDone), 0);
        step(1'b0, 1'b0, 1'b1, 8'h78, 4'd3, 1'b1);

        // Read-first: read address 2 in the cycle it is written with 0xAA
        step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'h40, '0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'h41, '0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'hAA, 4'd2, 1'b1);
        step(1'b0, 1'b0, 1'b0, '0, 4'd2, 1'b1);
        step(1'b0, 1'b1, 1'b0, '0, '0, 1'b0);

        // Reset mid-load after 7 beats
        step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b1, 8'h60 + DW'(i), '0, 1'b0);
        idle();
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midload_reset");
        m_loading = 1'b0;
        m_done    = 1'b0;
        m_count   = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 2**AW; i++) step(1'b0, 1'b0, 1'b0, '0, AW'(i), 1'b1);

        // Start+abort together in DONE stays DONE; start alone restarts
        full_load(8'h80);
        step(1'b1, 1'b1, 1'b0, '0, '0, 1'b0);
        check("start_abort_done", 32'(bus.oDone), 1);
        step(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
        check("restart_done", 32'(bus.oDone), 0);
        check("restart_busy", 32'(bus.oBusy), 1);

        // Random phase
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(7) == 0, $urandom_range(15) == 0, $urandom_range(1) == 1,
                 DW'($urandom), AW'($urandom), 1'b1);
        end

        idle();
        idle();
        check("scoreboard_drain", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
